// File: rtl/mult_fxp_pipe.sv
// mult_fxp_pipe: pipelined multi-lane signed fixed-point multiplier with per-beat round/saturate modes
// and valid/ready flow control; stage 1 holds raw products when more than one stage is configured.
module mult_fxp_pipe #(
  parameter int DATA_WID    = 16,
  parameter int AUG_FCT_B   = 8,
  parameter int LANES       = 4,
  parameter int PIPE_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_WID-1:0] in_a,
  input  logic [LANES*DATA_WID-1:0] in_b,
  input  logic [1:0]                in_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_WID-1:0] out_p,
  output logic [LANES-1:0]          out_sat,
  output logic                      sat_sticky,
  input  logic                      clr_sat
);
  localparam int W = DATA_WID;
  localparam int S = PIPE_STAGES;
  localparam int P = (S > 1) ? 1 : 0;
  localparam int R = S - P;
  localparam int RSH = (AUG_FCT_B > 0) ? AUG_FCT_B - 1 : 0;
  localparam logic signed [2*W:0] MAXV = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W:0] MINV = {{(W+2){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [2*W:0] RND = (AUG_FCT_B > 0) ? ({{(2*W){1'b0}}, 1'b1} << RSH) : '0;

  function automatic logic [2*W-1:0] mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] x, y;
    x = {{W{a[W-1]}}, a};
    y = {{W{b[W-1]}}, b};
    return x * y;
  endfunction

  // one extra bit keeps the rounding add from overflowing
  function automatic logic [W:0] post(input logic [2*W-1:0] p, input logic [1:0] m);
    logic signed [2*W:0] r, s;
    logic hi, lo;
    r = $signed({p[2*W-1], p}) + (m[0] ? RND : '0);
    s = r >>> AUG_FCT_B;
    hi = m[1] & (s > MAXV);
    lo = m[1] & (s < MINV);
    return {hi | lo, hi ? MAXV[W-1:0] : lo ? MINV[W-1:0] : s[W-1:0]};
  endfunction

  logic [S-1:0]                   vld_q, go, vin;
  logic [LANES*2*W-1:0]           prod_d, pp;
  logic [1:0]                     pm;
  logic [LANES*W-1:0]             res_d;
  logic [LANES-1:0]               sat_d;
  logic [R-1:0][LANES*W-1:0]      res_q, res_src;
  logic [R-1:0][LANES-1:0]        sat_q, sat_src;
  logic                           sticky_q;

  assign vin     = S'({vld_q, in_valid});
  assign res_src = (R*LANES*W)'({res_q, res_d});
  assign sat_src = (R*LANES)'({sat_q, sat_d});

  // a stage may load when it or any stage downstream has a hole, or the output drains
  always_comb begin
    for (int k = 0; k < S; k++) begin
      go[k] = out_ready;
      for (int j = k; j < S; j++) go[k] = go[k] | ~vld_q[j];
    end
  end

  always_comb begin
    prod_d = '0;
    res_d  = '0;
    sat_d  = '0;
    for (int i = 0; i < LANES; i++) begin
      prod_d[i*2*W +: 2*W] = mul(in_a[i*W +: W], in_b[i*W +: W]);
      {sat_d[i], res_d[i*W +: W]} = post(pp[i*2*W +: 2*W], pm);
    end
  end

  generate
    if (S > 1) begin : g_raw
      logic [LANES*2*W-1:0] prod_q;
      logic [1:0]           mode_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prod_q <= '0;
          mode_q <= '0;
        end else if (go[0] & in_valid) begin
          prod_q <= prod_d;
          mode_q <= in_mode;
        end
      end
      assign pp = prod_q;
      assign pm = mode_q;
    end else begin : g_comb
      assign pp = prod_d;
      assign pm = in_mode;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      res_q    <= '0;
      sat_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      for (int k = 0; k < S; k++) if (go[k]) vld_q[k] <= vin[k];
      for (int j = 0; j < R; j++) begin
        if (go[P+j] & vin[P+j]) begin
          res_q[j] <= res_src[j];
          sat_q[j] <= sat_src[j];
        end
      end
      sticky_q <= ~clr_sat & (sticky_q | (out_valid & out_ready & |out_sat));
    end
  end

  assign in_ready   = go[0];
  assign out_valid  = vld_q[S-1];
  assign out_p      = res_q[R-1];
  assign out_sat    = sat_q[R-1];
  assign sat_sticky = sticky_q;
endmodule

// File: tb/tb_mult_fxp_pipe.sv
// tb_mult_fxp_pipe: table-driven check of mult_fxp_pipe (Q8.8, 4 lanes, 2 stages) with a scoreboard monitor
// and directed sequences for latency, backpressure, sticky clear and asynchronous reset.
module tb_mult_fxp_pipe;
  localparam int S = 2;

  typedef struct {
    logic [63:0] a, b;
    logic [1:0]  m;
    logic [63:0] p;
    logic [3:0]  s;
  } vec_t;

  logic        clk = 0, rst_n = 1, in_valid = 0, out_ready = 1, clr_sat = 0;
  logic        in_ready, out_valid, sat_sticky;
  logic [63:0] in_a = '0, in_b = '0, out_p, exp_p = '0, pp = '0;
  logic [1:0]  in_mode = '0;
  logic [3:0]  out_sat, exp_s = '0, ps = '0;
  logic        pv = 0, pr = 0, mon_en = 0;
  logic [67:0] e;
  int          tests = 0, fails = 0;
  vec_t        tbl[8];
  vec_t        tx[$];
  logic [67:0] sb[$];

  mult_fxp_pipe #(.DATA_WID(16), .AUG_FCT_B(8), .LANES(4), .PIPE_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_p(out_p), .out_sat(out_sat),
    .sat_sticky(sat_sticky), .clr_sat(clr_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_a = v.a; in_b = v.b; in_mode = v.m; exp_p = v.p; exp_s = v.s; in_valid = 1;
  endtask

  function automatic vec_t inc(input int k);
    vec_t v;
    v.a = '0; v.p = '0; v.b = {4{16'h0200}}; v.m = 2'(k); v.s = '0;
    for (int i = 0; i < 4; i++) begin
      v.a[i*16 +: 16] = 16'(k*4 + i + 1);
      v.p[i*16 +: 16] = 16'(2*(k*4 + i + 1));
    end
    return v;
  endfunction

  // scoreboard: push on input transfer, pop and compare on output transfer, check stall stability
  always begin
    @(negedge clk); #4;
    if (mon_en) begin
      if (pv && !pr) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_p", out_p, pp);
        chk("stall_sat", 64'(out_sat), 64'(ps));
      end
      if (in_valid && in_ready) sb.push_back({exp_s, exp_p});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_beat: got %h expected no beat", out_p);
        end else begin
          e = sb.pop_front();
          chk("out_p", out_p, e[63:0]);
          chk("out_sat", 64'(out_sat), 64'(e[67:64]));
        end
      end
    end
    pv = out_valid; pr = out_ready; pp = out_p; ps = out_sat;
  end

  task automatic drain();
    @(negedge clk); in_valid = 0; out_ready = 1;
    repeat (S + 2) @(negedge clk);
    chk("drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic lat_beat(input vec_t v);
    int n = 1;
    @(negedge clk); out_ready = 1; drive(v);
    #4 chk("lat_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); in_valid = 0;
    while (!out_valid && n < 10) begin @(negedge clk); n++; end
    chk("latency", 64'(n), 64'(S));
    drain();
  endtask

  task automatic run_stream(input bit rnd);
    int idx = 0, cyc = 0;
    while (idx < tx.size() && cyc < 1000) begin
      @(negedge clk);
      out_ready = !rnd || ((cyc < 6 || cyc > 10) && $urandom_range(0, 1) == 1);
      drive(tx[idx]);
      #4 if (in_ready) idx++;
      cyc++;
    end
    chk("stream_sent", 64'(idx), 64'(tx.size()));
    if (!rnd) chk("full_rate", 64'(cyc), 64'(tx.size()));
    drain();
  endtask

  task automatic hold_fill(input int base);
    int idx = 0;
    repeat (S + 3) begin
      @(negedge clk); out_ready = 0; drive(inc(base + idx));
      #4 if (in_ready) idx++;
    end
    chk("held_count", 64'(idx), 64'(S));
    chk("in_ready_low", 64'(in_ready), 64'd0);
  endtask

  initial begin
    tbl[0] = '{a:64'hFFFF_0001_FE80_0180, b:64'h0080_0080_0200_0200, m:2'd0, p:64'hFFFF_0000_FD00_0300, s:4'b0000};
    tbl[1] = '{a:64'hFFFF_0001_FE80_0180, b:64'h0080_0080_0200_0200, m:2'd1, p:64'h0000_0001_FD00_0300, s:4'b0000};
    tbl[2] = '{a:64'h8000_7FFF_8000_7F00, b:64'h0100_0100_7FFF_7F00, m:2'd2, p:64'h8000_7FFF_8000_7FFF, s:4'b0011};
    tbl[3] = '{a:64'h8000_FFFF_0001_7F80, b:64'h8000_0080_0080_0101, m:2'd3, p:64'h7FFF_0000_0001_7FFF, s:4'b1001};
    tbl[4] = '{a:64'h8000_FFFF_0001_7F80, b:64'h8000_0080_0080_0101, m:2'd0, p:64'h0000_FFFF_0000_7FFF, s:4'b0000};
    tbl[5] = '{a:64'h8000_FFFF_0001_7F80, b:64'h8000_0080_0080_0101, m:2'd1, p:64'h0000_0000_0001_8000, s:4'b0000};
    tbl[6] = '{a:64'h8000_FFFF_0001_7F80, b:64'h8000_0080_0080_0101, m:2'd2, p:64'h7FFF_FFFF_0000_7FFF, s:4'b1000};
    tbl[7] = '{a:64'h8000_7FFF_8000_7F00, b:64'h0100_0100_7FFF_7F00, m:2'd0, p:64'h8000_7FFF_0080_0100, s:4'b0000};
    #1 rst_n = 0;
    #6;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_p", out_p, 64'd0);
    chk("rst_out_sat", 64'(out_sat), 64'd0);
    chk("rst_sticky", 64'(sat_sticky), 64'd0);
    @(negedge clk); rst_n = 1;
    #1 chk("rst_in_ready", 64'(in_ready), 64'd1);
    mon_en = 1;
    lat_beat(tbl[0]);
    for (int i = 0; i < 8; i++) tx.push_back(tbl[i]);
    run_stream(0);
    chk("sticky_set", 64'(sat_sticky), 64'd1);
    @(negedge clk); clr_sat = 1;
    @(negedge clk); clr_sat = 0;
    chk("sticky_clr", 64'(sat_sticky), 64'd0);
    begin
      int n = 1;
      @(negedge clk); out_ready = 1; drive(tbl[2]);
      @(negedge clk); in_valid = 0;
      while (!out_valid && n < 10) begin @(negedge clk); n++; end
      chk("clr_setup", 64'(n), 64'(S));
      clr_sat = 1;
      @(negedge clk); clr_sat = 0;
      chk("sticky_same_cycle", 64'(sat_sticky), 64'd0);
      drain();
    end
    hold_fill(100);
    drain();
    tx.delete();
    for (int k = 0; k < 20; k++) tx.push_back(inc(k));
    run_stream(1);
    lat_beat(tbl[2]);
    chk("sticky_pre_rst", 64'(sat_sticky), 64'd1);
    hold_fill(200);
    chk("full_pre_rst", 64'(out_valid), 64'd1);
    @(negedge clk); in_valid = 0;
    #2 mon_en = 0; rst_n = 0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_p", out_p, 64'd0);
    chk("midrst_out_sat", 64'(out_sat), 64'd0);
    chk("midrst_sticky", 64'(sat_sticky), 64'd0);
    sb.delete();
    @(negedge clk); rst_n = 1;
    #1 chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    mon_en = 1;
    lat_beat(tbl[1]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mult_fxp_pipe.md
Name: mult_fxp_pipe

Overview:
Pipelined, multi-lane signed fixed-point multiplier. It is the successor to the single combinational multiplier used in the CNN/LSTM datapaths. It adds parametrised lane count, pipeline depth, per-beat rounding and saturation modes, and valid/ready flow control with backpressure. It sits between operand fetch (weights × activations) and the accumulator/activation units.

Parameters:
DATA_WID, 16, operand and result width in bits, two's complement.
AUG_FCT_B, 8, fractional bits (Q format). Range 0..DATA_WID-1.
LANES, 4, independent multipliers sharing one handshake.
PIPE_STAGES, 2, register stages from input to output. Minimum 1.

Ports:
clk  in  1  clock; all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  input beat valid.
in_ready  out  1  block can accept a beat this cycle.
in_a  in  LANES*DATA_WID  operand A; lane i at [i*DATA_WID +: DATA_WID].
in_b  in  LANES*DATA_WID  operand B; same packing.
in_mode  in  2  bit0=round (1) / truncate (0); bit1=saturate (1) / wrap (0). Sampled with the beat.
out_valid  out  1  output beat valid.
out_ready  in  1  consumer accepts the beat.
out_p  out  LANES*DATA_WID  results, same packing.
out_sat  out  LANES  per-lane flag: saturation clipped this beat.
sat_sticky  out  1  OR of all out_sat over transferred beats since last clear.
clr_sat  in  1  synchronous clear of sat_sticky. Wins over a same-cycle set.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valids=0, out_valid=0, out_p=0, out_sat=0, sat_sticky=0. in_ready=1 once rst_n is high. Data in flight is discarded.
- Transfers occur on cycles where valid&ready is high at the edge.
  - Input transfer requires in_valid&in_ready.
  - Output transfer requires out_valid&out_ready.
- Pipeline: PIPE_STAGES stages, each with a valid bit.
  - A stage loads when it is empty or its contents advance this cycle.
  - in_ready = stage 1 empty OR stage 1 advances. It is combinational from out_ready through the stall chain; there are no bubbles at full throughput.
  - Throughput is 1 beat/cycle. Latency is PIPE_STAGES cycles from input transfer to out_valid with out_ready held high.
- Backpressure: when out_ready=0, all stages hold. Beats are never dropped, duplicated or reordered. Output data and flags are stable while out_valid=1 and out_ready=0.
- Arithmetic per lane:
  - prod = A*B, full 2*DATA_WID signed.
  - Round mode with AUG_FCT_B>0: prod_r = prod + 2^(AUG_FCT_B-1), i.e. round half toward +inf. Otherwise prod_r = prod.
  - shifted = prod_r >>> AUG_FCT_B (arithmetic shift).
  - Saturate mode: if shifted > 2^(DATA_WID-1)-1, result = max positive and out_sat=1. If shifted < -2^(DATA_WID-1), result = min negative and out_sat=1. Otherwise result = shifted[DATA_WID-1:0] and out_sat=0.
  - Wrap mode: result = shifted[DATA_WID-1:0] and out_sat=0. Wrap+truncate is bit-identical to the legacy single multiplier.
  - The rounding add must not overflow: compute it with one extra bit.
- Stage placement:
  - PIPE_STAGES=1: multiply, round and saturate are combinational into stage 1.
  - PIPE_STAGES>=2: stage 1 registers the raw product and mode; round and saturate sit between stage 1 and stage 2; later stages are pure delay.
- sat_sticky sets on an output transfer with any out_sat bit set. clr_sat clears it; clr_sat has priority over a same-cycle set.
- Reset mid-operation: outputs clear immediately. The first post-reset beat sees an empty pipeline.

Test Plan:
- Q8.8 (W=16, F=8), wrap/truncate, all lanes: 0x0180×0x0200 gives 0x0300; 0xFE80×0x0200 gives 0xFD00. out_valid appears exactly PIPE_STAGES cycles after input with out_ready=1.
- Rounding: 0x0001×0x0080 gives 0x0000 truncate, 0x0001 round. 0xFFFF×0x0080 gives 0xFFFF truncate, 0x0000 round.
- Saturation: 0x7F00×0x7F00 gives 0x7FFF, out_sat=1 in saturate mode, and 0x0100, out_sat=0 in wrap mode. 0x8000×0x7FFF saturates to 0x8000. Check sat_sticky=1 afterwards, then clr_sat gives 0. clr_sat asserted in the same cycle as a saturating transfer leaves sat_sticky at 0.
- Backpressure: stream 20 beats with incrementing operands and out_ready toggled randomly, including a 5-cycle low. in_ready must drop after PIPE_STAGES beats are held. The output sequence must equal the input order exactly, with stable data during stalls.
- Mixed modes per beat: alternate in_mode 0..3 on consecutive beats. Each result uses its own beat's mode, which confirms mode travels with the data.
- Reset mid-stream: assert rst_n low asynchronously between edges with the pipeline full. out_valid, out_p, out_sat and sat_sticky go to 0 without a clock edge. The first beat after release returns in PIPE_STAGES cycles with the correct value.
